// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch front end.
//   fetch_state_e  : sequencer states IDLE / REQ / DRAIN
//   FETCH_ADDR_W   : default PC / address width
//   FETCH_INST_W   : default instruction width
//   FETCH_RESET_PC : default first fetch address after reset
//   PC_STEP        : sequential PC increment in bytes
//   fetch_entry_t  : one fetched entry {pc, inst, excp} at default widths
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W   = 32;
  localparam int unsigned FETCH_INST_W   = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_STEP        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
    logic                    excp;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_npc_sel.sv
// fetch_npc_sel: combinational next-fetch-address priority mux.
//   excp_flag / excp_target     : exception redirect (highest priority)
//   branch_flag / branch_target : branch redirect
//   pend_flag / pend_target     : redirect latched while a fetch was in flight
//   seq_pc                      : sequential address (lowest priority)
//   npc                         : selected next fetch address
//   redir_taken                 : a new redirect arrived this cycle
module fetch_npc_sel
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W
) (
  input  logic              excp_flag,
  input  logic [ADDR_W-1:0] excp_target,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              pend_flag,
  input  logic [ADDR_W-1:0] pend_target,
  input  logic [ADDR_W-1:0] seq_pc,
  output logic [ADDR_W-1:0] npc,
  output logic              redir_taken
);

  always_comb begin
    redir_taken = excp_flag | branch_flag;
    if (excp_flag) begin
      npc = excp_target;
    end else if (branch_flag) begin
      npc = branch_target;
    end else if (pend_flag) begin
      npc = pend_target;
    end else begin
      npc = seq_pc;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: program-counter sequencer and instruction-memory fetch port.
// Keeps one fetch outstanding on a req/ack port, drops responses made stale by
// a redirect, and presents {pc, inst} to decode through a registered slot
// backed by a one-entry hold buffer so decode stalls are honoured.
// Optional build macro: PC_ALIGN_CHECK_EN (misaligned redirect targets raise
// an address-fetch exception instead of being fetched; otherwise the low two
// target bits are cleared).
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   stall_i                           : decode cannot accept, hold the slot
//   branch_flag_i / branch_target_i   : branch redirect pulse and target
//   excp_flag_i / excp_target_i       : exception redirect pulse and target
//   inst_req_o / inst_addr_o          : fetch request and address
//   inst_ack_i / inst_rdata_i         : memory accept and returned instruction
//   inst_valid_o / inst_o / pc_o      : output slot to decode
//   excp_adef_o, inst_excp_o          : (PC_ALIGN_CHECK_EN only) misalign pulse
//                                       and slot exception marker
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned        INST_W   = FETCH_INST_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              excp_flag_i,
  input  logic [ADDR_W-1:0] excp_target_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ack_i,
  input  logic [INST_W-1:0] inst_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic              excp_adef_o,
  output logic              inst_excp_o
`endif
);

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_STEP);
  endfunction

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pend_mis_q, pend_mis_d;

  logic              vld_p0;
  logic [ADDR_W-1:0] pc_p0;
  logic [INST_W-1:0] inst_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [INST_W-1:0] inst_p1;

  logic              ack_hs;
  logic [ADDR_W-1:0] br_tgt, ex_tgt, seq_pc, npc;
  logic              redir_taken, misalign;
  logic              slot_ld, slot_clr, slot_pseudo, hold_ld, hold_clr;
  logic [ADDR_W-1:0] slot_src_pc;
  logic [INST_W-1:0] slot_src_inst;

`ifdef PC_ALIGN_CHECK_EN
  assign br_tgt   = branch_target_i;
  assign ex_tgt   = excp_target_i;
  assign misalign = redir_taken && (npc[1:0] != 2'b00);
`else
  assign br_tgt   = branch_target_i & ~ADDR_W'(3);
  assign ex_tgt   = excp_target_i & ~ADDR_W'(3);
  assign misalign = 1'b0;
`endif

  assign ack_hs = req_q & inst_ack_i;

  always_comb begin
    case (state_q)
      ST_IDLE:  seq_pc = RESET_PC;
      ST_DRAIN: seq_pc = pc_inc(pc_p0);
      default:  seq_pc = pc_inc(addr_q);
    endcase
  end

  fetch_npc_sel #(
    .ADDR_W (ADDR_W)
  ) u_npc_sel (
    .excp_flag     (excp_flag_i),
    .excp_target   (ex_tgt),
    .branch_flag   (branch_flag_i),
    .branch_target (br_tgt),
    .pend_flag     (pend_q),
    .pend_target   (pend_tgt_q),
    .seq_pc        (seq_pc),
    .npc           (npc),
    .redir_taken   (redir_taken)
  );

  // ---- p0: fetch handshake, redirect handling, hold-buffer capture ----
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    addr_d        = addr_q;
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
    pend_mis_d    = pend_mis_q;
    slot_ld       = 1'b0;
    slot_clr      = 1'b0;
    slot_pseudo   = 1'b0;
    hold_ld       = 1'b0;
    hold_clr      = 1'b0;
    slot_src_pc   = addr_q;
    slot_src_inst = inst_rdata_i;

    if (redir_taken) begin
      slot_clr    = 1'b1;
      hold_clr    = 1'b1;
      slot_pseudo = misalign;
      state_d     = ST_REQ;
      if (req_q && !inst_ack_i) begin
        // address must stay put until the in-flight fetch is acked
        pend_d     = 1'b1;
        pend_tgt_d = npc;
        pend_mis_d = misalign;
      end else begin
        pend_d     = 1'b0;
        pend_mis_d = 1'b0;
        addr_d     = npc;
        req_d      = !misalign;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = npc;
        end
        ST_REQ: begin
          if (ack_hs && pend_q) begin
            pend_d     = 1'b0;
            pend_mis_d = 1'b0;
            addr_d     = npc;
            req_d      = !pend_mis_q;
          end else if (ack_hs && (!vld_p1 || !stall_i)) begin
            slot_ld = 1'b1;
            addr_d  = npc;
          end else if (ack_hs) begin
            hold_ld = 1'b1;
            req_d   = 1'b0;
            state_d = ST_DRAIN;
          end
          if (!slot_ld && !stall_i) begin
            slot_clr = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!stall_i && vld_p0) begin
            slot_ld       = 1'b1;
            slot_src_pc   = pc_p0;
            slot_src_inst = inst_p0;
            hold_clr      = 1'b1;
            state_d       = ST_REQ;
            req_d         = 1'b1;
            addr_d        = npc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      pend_q     <= 1'b0;
      pend_mis_q <= 1'b0;
      vld_p0     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      pend_mis_q <= pend_mis_d;
      if (hold_clr) begin
        vld_p0 <= 1'b0;
      end else if (hold_ld) begin
        vld_p0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
    if (hold_ld) begin
      pc_p0   <= addr_q;
      inst_p0 <= inst_rdata_i;
    end
  end

  // ---- p1: output slot to decode ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      inst_p1 <= '0;
    end else if (slot_pseudo) begin
      vld_p1  <= 1'b1;
      pc_p1   <= npc;
      inst_p1 <= '0;
    end else if (slot_clr) begin
      vld_p1  <= 1'b0;
    end else if (slot_ld) begin
      vld_p1  <= 1'b1;
      pc_p1   <= slot_src_pc;
      inst_p1 <= slot_src_inst;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic excp_p1;
  logic adef_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      excp_p1 <= 1'b0;
      adef_p1 <= 1'b0;
    end else begin
      adef_p1 <= slot_pseudo;
      if (slot_pseudo) begin
        excp_p1 <= 1'b1;
      end else if (slot_ld) begin
        excp_p1 <= 1'b0;
      end
    end
  end

  assign excp_adef_o = adef_p1;
  assign inst_excp_o = excp_p1;
`endif

  assign inst_req_o   = req_q;
  assign inst_addr_o  = addr_q;
  assign inst_valid_o = vld_p1;
  assign inst_o       = inst_p1;
  assign pc_o         = pc_p1;

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Front-end sequencer for the program counter and instruction-memory fetch port.
- Selects the next PC with fixed priority: exception redirect, then branch redirect, then sequential +4.
- Issues one outstanding fetch request at a time on a req/ack port and discards responses made stale by a redirect.
- Delivers an instruction and its PC to decode through a registered output slot backed by a one-entry hold buffer, so decode stalls are honoured.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC and address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- stall_i  in  1  decode cannot accept; hold the output slot.
- branch_flag_i  in  1  branch redirect request (single-cycle pulse).
- branch_target_i  in  ADDR_W  branch target.
- excp_flag_i  in  1  exception redirect request (single-cycle pulse).
- excp_target_i  in  ADDR_W  exception entry address.
- inst_req_o  out  1  fetch request valid.
- inst_addr_o  out  ADDR_W  fetch address; stable while inst_req_o=1 and no ack.
- inst_ack_i  in  1  memory accepts and returns data this cycle.
- inst_rdata_i  in  INST_W  returned instruction, valid with inst_ack_i.
- inst_valid_o  out  1  output slot holds a valid instruction.
- inst_o  out  INST_W  instruction to decode.
- pc_o  out  ADDR_W  PC of inst_o.

Behaviour:
- Reset (rst=0, asynchronous):
  - inst_req_o=0, inst_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0.
  - Hold buffer empty, discard flag clear, state=IDLE.
- FSM states: IDLE, REQ, DRAIN.
  - IDLE: entered only from reset. On the first clk edge after reset release, go to REQ with inst_addr_o=RESET_PC and inst_req_o=1.
  - REQ: inst_req_o=1 and inst_addr_o held until inst_ack_i. Latency is one cycle minimum from request to ack.
  - On ack with no pending redirect, capture {inst_addr_o, inst_rdata_i}:
    - Into the output slot if the slot is empty or stall_i=0.
    - Otherwise into the hold buffer.
  - A new request is issued only when the hold buffer will be empty at the next edge. If the hold buffer is full, go to DRAIN with inst_req_o=0.
  - DRAIN: wait for stall_i=0. Then move hold buffer to slot, return to REQ, and set next address = captured PC + 4.
- Redirect (excp_flag_i or branch_flag_i, exception wins if both):
  - The redirect target becomes the next fetch address.
  - Output slot and hold buffer are invalidated on the next edge: inst_valid_o=0 even if stall_i=1.
  - If a request is mid-handshake (inst_req_o=1, no ack this cycle), inst_addr_o stays unchanged and the discard flag is set with the target latched. The acked data is dropped, and the next request uses the latched target.
  - A redirect in the same cycle as an ack drops that ack's data. The next request uses the target in the following cycle.
  - A second redirect while the discard flag is set overwrites the latched target.
- Sequential next PC: captured PC + 4, modulo 2^ADDR_W. 32'hFFFF_FFFC wraps to 0.
- Output slot:
  - Loads when (!inst_valid_o || !stall_i) and a valid source exists. Source priority is hold buffer, then new ack.
  - When stall_i=0 and no source exists, inst_valid_o clears.
- A reset asserted mid-handshake aborts immediately. Memory must tolerate req dropping.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output excp_adef_o (1 bit) and inst_excp_o (1 bit), both reset 0.
  - A redirect target with bits[1:0]!=0 is not fetched. A pseudo-instruction with inst_o=0, pc_o=target and inst_excp_o=1 is placed in the slot, and excp_adef_o pulses for 1 cycle.
  - Fetching stops (REQ idle, inst_req_o=0) until the next redirect.
- Undefined: no extra ports; target bits[1:0] are forced to 0.

Decomposition:
- Package fetch_pkg:
  - FSM state enum (IDLE/REQ/DRAIN).
  - ADDR_W/INST_W defaults, RESET_PC default, PC_STEP=4.
  - Fetch-entry struct {pc, inst, excp}.
- One sub-module: fetch_npc_sel, a combinational priority mux (exception, branch, latched redirect, sequential) producing the next address and a redirect-taken flag.

Test Plan:
- Reset release, ack on every 2nd cycle, stall_i=0 -> addresses 0x0, 0x4, 0x8; pc_o/inst_o follow with inst_valid_o pulses.
- stall_i=1 for 5 cycles while a request is pending -> ack goes into hold buffer, inst_req_o=0 (DRAIN). On stall release, the slot shows the held entry, then the request resumes at held PC + 4.
- branch_flag_i=1 target 0x100 while REQ at 0x20 without ack -> inst_addr_o stays 0x20 until ack, data dropped, next request 0x100, no valid output for 0x20.
- excp_flag_i and branch_flag_i same cycle (targets 0x800, 0x100) -> next fetch 0x800.
- Fetch PC 0xFFFF_FFFC -> next request 0x0000_0000.
- PC_ALIGN_CHECK_EN, branch to 0x102 -> excp_adef_o 1-cycle pulse, inst_excp_o=1, pc_o=0x102, inst_req_o=0 until the next redirect.
